// File: rtl/adpll_seq_if.sv
// adpll_seq_if: register bus between the ADPLL tuning sequencer and the ADPLL CSR block.
// Default widths for the CSR map are defined here and in adpll_seq.sv, each guarded,
// so the two files can be compiled in either order or on their own.
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif

// Handshake: the master raises valid for exactly one cycle with address, wdata and
// wstrb (1 = write, 0 = read) valid, then drops valid and holds address, wdata and
// wstrb until the slave answers with a one-cycle ready. rdata is meaningful only in
// the ready cycle of a read. ready is only looked at after the valid cycle.
interface adpll_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = `ADPLL_ADDR_W
);
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, output address, output wdata, output wstrb,
                  input rdata, input ready);
  modport slave  (input valid, input address, input wdata, input wstrb,
                  output rdata, output ready);
endinterface

// File: rtl/adpll_seq.sv
// adpll_seq: channel (re)tune sequencer for an ADPLL. On start it disables the ADPLL,
// programs FCW and mode, pulses soft reset, re-enables, polls for lock within a cycle
// budget and finally reads the saturation flag (or disables the ADPLL on timeout).
// Optional feature: define ADPLL_SEQ_RETRY_EN to retry the soft-reset/lock phase up
// to three attempts before declaring a timeout.
// State is exposed on dbg_state for checkers.
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef FCWW
`define FCWW 28
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 8'h00
`endif
`ifndef FCW
`define FCW 8'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 8'h08
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 8'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 8'h10
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 8'h14
`endif

module adpll_seq #(
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [`FCWW-1:0]     fcw_in,
  input  logic [1:0]           mode_in,
  input  logic [TIMEOUT_W-1:0] timeout,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic                 sat_err,
  output logic                 timeout_err,
  output logic [3:0]           dbg_state,
  adpll_seq_if.master          bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WR_EN0  = 4'd1,
    WR_FCW  = 4'd2,
    WR_MODE = 4'd3,
    WR_RST1 = 4'd4,
    WR_RST0 = 4'd5,
    WR_EN1  = 4'd6,
    POLL    = 4'd7,
    RD_SAT  = 4'd8,
    FAIL    = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t                state_q, state_d;
  // phase 0: valid cycle of the current access; phase 1: waiting for ready
  logic                  phase_q, phase_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [`FCWW-1:0]      fcw_q;
  logic [1:0]            mode_q;
  logic [TIMEOUT_W-1:0]  timeout_q;
  logic                  accept, is_access, done_xfer, set_lock, set_fail;
  logic [`ADPLL_ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0]     wdata_c;
  logic                  wstrb_c;
  // only bit 0 of read data carries status
  logic                  unused_rdata;

`ifdef ADPLL_SEQ_RETRY_EN
  logic [1:0]            retry_q, retry_d;
`endif

  assign accept       = (state_q == IDLE) && start;
  assign is_access    = (state_q != IDLE) && (state_q != DONE);
  assign done_xfer    = is_access && phase_q && bus.ready;
  assign unused_rdata = ^bus.rdata[DATA_W-1:1];

  // state, access phase and poll-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ADPLL_SEQ_RETRY_EN
  // lock-attempt counter, restarted by each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= 2'd0;
    else        retry_q <= retry_d;
  end
`endif

  // next-state logic: advance on the ready of each access, decide lock/timeout in POLL
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    set_lock = 1'b0;
    set_fail = 1'b0;
`ifdef ADPLL_SEQ_RETRY_EN
    retry_d  = retry_q;
`endif
    if (is_access && !phase_q) phase_d = 1'b1;
    if (done_xfer)             phase_d = 1'b0;
    // poll counter saturates rather than wrapping
    if (state_q == POLL && cnt_q != {TIMEOUT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR_EN0;
          phase_d = 1'b0;
`ifdef ADPLL_SEQ_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      WR_EN0:  if (done_xfer) state_d = WR_FCW;
      WR_FCW:  if (done_xfer) state_d = WR_MODE;
      WR_MODE: if (done_xfer) state_d = WR_RST1;
      WR_RST1: if (done_xfer) state_d = WR_RST0;
      WR_RST0: if (done_xfer) state_d = WR_EN1;
      WR_EN1: begin
        if (done_xfer) begin
          state_d = POLL;
          cnt_d   = '0;
        end
      end
      POLL: begin
        if (done_xfer) begin
          if (bus.rdata[0]) begin
            state_d = RD_SAT;
          end else if (cnt_q >= timeout_q) begin
`ifdef ADPLL_SEQ_RETRY_EN
            if (retry_q != 2'd2) begin
              retry_d = retry_q + 2'd1;
              state_d = WR_RST1;
            end else begin
              state_d = FAIL;
            end
`else
            state_d = FAIL;
`endif
          end
        end
      end
      RD_SAT: begin
        if (done_xfer) begin
          state_d  = DONE;
          set_lock = 1'b1;
        end
      end
      FAIL: begin
        if (done_xfer) begin
          state_d  = DONE;
          set_fail = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus request decode: address/data/strobe follow the state and so hold until ready
  always_comb begin
    addr_c  = '0;
    wdata_c = '0;
    wstrb_c = 1'b0;
    case (state_q)
      WR_EN0, FAIL: begin
        addr_c  = `ADPLL_EN;
        wstrb_c = 1'b1;
      end
      WR_FCW: begin
        addr_c  = `FCW;
        wdata_c = DATA_W'(fcw_q);
        wstrb_c = 1'b1;
      end
      WR_MODE: begin
        addr_c  = `ADPLL_MODE;
        wdata_c = DATA_W'(mode_q);
        wstrb_c = 1'b1;
      end
      WR_RST1: begin
        addr_c     = `ADPLL_SOFT_RST;
        wdata_c[0] = 1'b1;
        wstrb_c    = 1'b1;
      end
      WR_RST0: begin
        addr_c  = `ADPLL_SOFT_RST;
        wstrb_c = 1'b1;
      end
      WR_EN1: begin
        addr_c     = `ADPLL_EN;
        wdata_c[0] = 1'b1;
        wstrb_c    = 1'b1;
      end
      POLL:    addr_c = `ADPLL_LOCK;
      RD_SAT:  addr_c = `ADPLL_SAT;
      default: addr_c = '0;
    endcase
  end

  assign bus.valid   = is_access && !phase_q;
  assign bus.address = addr_c;
  assign bus.wdata   = wdata_c;
  assign bus.wstrb   = wstrb_c;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign dbg_state   = state_q;

  // operand capture on accepted start only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcw_q     <= '0;
      mode_q    <= 2'd0;
      timeout_q <= '0;
    end else if (accept) begin
      fcw_q     <= fcw_in;
      mode_q    <= mode_in;
      timeout_q <= timeout;
    end
  end

  // result flags: set on the way into DONE, held until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked      <= 1'b0;
      sat_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      locked      <= 1'b0;
      sat_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (set_lock) begin
      locked  <= 1'b1;
      sat_err <= bus.rdata[0];
    end else if (set_fail) begin
      locked      <= 1'b0;
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/adpll_seq.md
ADPLL_SEQ -- requirements
Module: adpll_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the register bus data.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, meaning the width of the lock-timeout counter.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, width 1: request a channel (re)tune, sampled only in IDLE.
REQ-006 SHALL have port fcw_in, input, width `FCWW: target FCW, captured on accepted start.
REQ-007 SHALL have port mode_in, input, width 2: target adpll_mode, captured on accepted start.
REQ-008 SHALL have port timeout, input, width TIMEOUT_W: lock-wait limit in clk cycles, captured on accepted start.
REQ-009 SHALL have port busy, output, width 1: high in any state other than IDLE.
REQ-010 SHALL have port done, output, width 1: one-cycle pulse at sequence end.
REQ-011 SHALL have port locked, output, width 1: final lock status.
REQ-012 SHALL have port sat_err, output, width 1: channel saturation flag read after lock.
REQ-013 SHALL have port timeout_err, output, width 1: no lock within the timeout.
REQ-014 SHALL have the following register-bus master ports: valid (output, 1), address (output, `ADPLL_ADDR_W), wdata (output, DATA_W), wstrb (output, 1), rdata (input, DATA_W), ready (input, 1).

Function
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, and captured operands are unchanged.
REQ-016 SHALL perform each bus access as follows: valid=1 for exactly one cycle with address, wdata and wstrb valid; valid=0 afterwards, with address, wdata and wstrb held, until ready=1; then advance state.
REQ-017 SHALL sample rdata in the cycle ready=1 during a read (wstrb=0).
REQ-018 SHALL issue its first valid in the cycle after start is accepted.
REQ-019 SHALL walk the states IDLE -> WR_EN0 (`ADPLL_EN<=0) -> WR_FCW (`FCW<=fcw) -> WR_MODE (`ADPLL_MODE<=mode) -> WR_RST1 (`ADPLL_SOFT_RST<=1) -> WR_RST0 (`ADPLL_SOFT_RST<=0) -> WR_EN1 (`ADPLL_EN<=1) -> POLL -> RD_SAT -> DONE -> IDLE.
REQ-020 SHALL zero-extend wdata to DATA_W for every write.
REQ-021 SHALL, in POLL, repeatedly read `ADPLL_LOCK and go to RD_SAT when rdata[0]=1.
REQ-022 SHALL run the POLL cycle counter from 0 on POLL entry, increment it every cycle, and never let it wrap.
REQ-023 SHALL go to FAIL when the POLL counter is >= the captured timeout at the end of a read returning 0; timeout=0 gives exactly one poll read.
REQ-024 SHALL, in FAIL, write `ADPLL_EN<=0 and then go to DONE with timeout_err=1 and locked=0.
REQ-025 SHALL, in RD_SAT, read `ADPLL_SAT and set sat_err=rdata[0] and locked=1.
REQ-026 SHALL hold locked, sat_err and timeout_err from DONE until the next accepted start, which clears all three in the same cycle.
REQ-027 SHALL assert done for exactly the one cycle spent in DONE.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: state=IDLE, valid=0, wstrb=0, address=0, wdata=0, busy=0, done=0, locked=0, sat_err=0, timeout_err=0, counters=0.
REQ-029 SHALL, on reset asserted mid-sequence, abandon the in-flight access without completing it; the next start restarts at WR_EN0.

Configuration
REQ-030 SHALL, with ADPLL_SEQ_RETRY_EN defined, on a timeout in POLL go back to WR_RST1 up to 2 more times (3 attempts total), with the POLL counter cleared per attempt; FAIL is entered only after the third timeout.
REQ-031 SHALL, without ADPLL_SEQ_RETRY_EN, enter FAIL on the first timeout, and no retry counter SHALL exist.

Verification
REQ-032 SHALL be verified by: fcw_in=0x2620000, mode_in=1, timeout=100, lock stub high 20 cycles after EN=1 -> writes EN=0, FCW=0x2620000, MODE=1, RST=1, RST=0, EN=1 in order, 2 cycles each; done pulse; locked=1; sat_err=0; timeout_err=0.
REQ-033 SHALL be verified by: lock never asserts, timeout=100, macro undefined -> about 100 cycles of polling, EN<=0 write, done, timeout_err=1, locked=0.
REQ-034 SHALL be verified by: same as REQ-033 with ADPLL_SEQ_RETRY_EN defined -> exactly 3 RST=1/RST=0 pairs, then timeout_err=1; with lock raised on attempt 2 -> locked=1, timeout_err=0.
REQ-035 SHALL be verified by: lock=1 and sat=1 on first poll -> locked=1, sat_err=1, done one cycle.
REQ-036 SHALL be verified by: second start with fcw_in=0x2700000 pulsed during WR_MODE -> ignored; the FCW written stays the first value; exactly one done.
REQ-037 SHALL be verified by: rst_n low during POLL -> all outputs 0 immediately; a following start produces the full sequence from EN=0.
